// File: rtl/exc_sequencer_if.sv
// Exception sequencer bus: decode-side requests in, datapath strobes and status out.
interface exc_sequencer_if #(
  parameter int unsigned ESR_W = 4
);
  logic             exc_inv;
  logic             exc_ext;
  logic             eret;
  logic             elr_en;
  logic             esr_en;
  logic [ESR_W-1:0] esr_d;
  logic             pc_sel_exc;
  logic             pc_sel_eret;
  logic             flush;
  logic             stall;
  logic             in_handler;
  logic             double_fault;

  modport master (
    output exc_inv, exc_ext, eret,
    input  elr_en, esr_en, esr_d, pc_sel_exc, pc_sel_eret,
           flush, stall, in_handler, double_fault
  );

  modport slave (
    input  exc_inv, exc_ext, eret,
    output elr_en, esr_en, esr_d, pc_sel_exc, pc_sel_eret,
           flush, stall, in_handler, double_fault
  );
endinterface

// File: rtl/exc_sequencer.sv
// Moore FSM sequencing LEGv8 exception entry (ELR, ESR, vector) and ERET return.
// Strobes are registered, decoded from the next state so they line up with the state.
module exc_sequencer #(
  parameter int unsigned ESR_W    = 4,
  parameter int unsigned CODE_INV = 1,
  parameter int unsigned CODE_EXT = 2
) (
  input  logic           clk,
  input  logic           reset,
  exc_sequencer_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    SAVE_ELR = 3'd1,
    SAVE_ESR = 3'd2,
    VECTOR   = 3'd3,
    RETURN   = 3'd4
  } state_e;

  state_e           state_q, state_d;
  logic [ESR_W-1:0] code_q, code_d;
  logic             in_handler_q, in_handler_d;
  logic             double_fault_q, double_fault_d;
  logic             elr_en_q, esr_en_q, pc_sel_exc_q, pc_sel_eret_q, flush_q, stall_q;

  // Next-state: requests are only arbitrated in IDLE; sync/ERET-outside-handler beat IRQ.
  always_comb begin
    state_d        = state_q;
    code_d         = code_q;
    in_handler_d   = in_handler_q;
    double_fault_d = double_fault_q;
    unique case (state_q)
      IDLE: begin
        if (bus.exc_inv || (bus.eret && !in_handler_q)) begin
          if (in_handler_q) begin
            double_fault_d = 1'b1;
          end else begin
            code_d  = ESR_W'(CODE_INV);
            state_d = SAVE_ELR;
          end
        end else if (bus.eret) begin
          state_d = RETURN;
        end else if (bus.exc_ext && !in_handler_q) begin
          code_d  = ESR_W'(CODE_EXT);
          state_d = SAVE_ELR;
        end
      end
      SAVE_ELR: state_d = SAVE_ESR;
      SAVE_ESR: state_d = VECTOR;
      VECTOR: begin
        in_handler_d = 1'b1;
        state_d      = IDLE;
      end
      RETURN: begin
        in_handler_d = 1'b0;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= IDLE;
      code_q         <= '0;
      in_handler_q   <= 1'b0;
      double_fault_q <= 1'b0;
      elr_en_q       <= 1'b0;
      esr_en_q       <= 1'b0;
      pc_sel_exc_q   <= 1'b0;
      pc_sel_eret_q  <= 1'b0;
      flush_q        <= 1'b0;
      stall_q        <= 1'b0;
    end else begin
      state_q        <= state_d;
      code_q         <= code_d;
      in_handler_q   <= in_handler_d;
      double_fault_q <= double_fault_d;
      elr_en_q       <= (state_d == SAVE_ELR);
      esr_en_q       <= (state_d == SAVE_ESR);
      pc_sel_exc_q   <= (state_d == VECTOR);
      pc_sel_eret_q  <= (state_d == RETURN);
      flush_q        <= (state_d == VECTOR) || (state_d == RETURN);
      stall_q        <= (state_d != IDLE);
    end
  end

  assign bus.elr_en       = elr_en_q;
  assign bus.esr_en       = esr_en_q;
  assign bus.esr_d        = code_q;
  assign bus.pc_sel_exc   = pc_sel_exc_q;
  assign bus.pc_sel_eret  = pc_sel_eret_q;
  assign bus.flush        = flush_q;
  assign bus.stall        = stall_q;
  assign bus.in_handler   = in_handler_q;
  assign bus.double_fault = double_fault_q;

endmodule

// File: tb/tb_exc_sequencer.sv
// Directed bench for exc_sequencer: entry/return latency, arbitration, double fault, reset abort.
module tb_exc_sequencer;

  localparam int unsigned ESR_W = 4;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  exc_sequencer_if #(.ESR_W(ESR_W)) bus ();

  exc_sequencer #(.ESR_W(ESR_W), .CODE_INV(1), .CODE_EXT(2)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Observed vector: {elr,esr,exc,eret,flush,stall,in_handler,double_fault,esr_d[3:0]}
  function automatic logic [11:0] obs();
    return {bus.elr_en, bus.esr_en, bus.pc_sel_exc, bus.pc_sel_eret, bus.flush,
            bus.stall, bus.in_handler, bus.double_fault, bus.esr_d};
  endfunction

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [11:0] exp);
    logic [11:0] o;
    o = obs();
    checks++;
    assert (o === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, o, exp);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset = 1'b1;
    bus.exc_inv = 1'b0;
    bus.exc_ext = 1'b0;
    bus.eret    = 1'b0;
    tick();
    tick();
    chk("reset", 12'b00000000_0000);
    reset = 1'b0;
    tick();
    chk("idle", 12'b00000000_0000);

    // Invalid opcode entry latency
    bus.exc_inv = 1'b1;
    tick();
    bus.exc_inv = 1'b0;
    chk("inv_save_elr", 12'b10000100_0001);
    tick();
    chk("inv_save_esr", 12'b01000100_0001);
    tick();
    chk("inv_vector", 12'b00101100_0001);
    tick();
    chk("inv_in_handler", 12'b00000010_0001);
    bus.eret = 1'b1;
    tick();
    bus.eret = 1'b0;
    chk("eret_return", 12'b00011110_0001);
    tick();
    chk("eret_idle", 12'b00000000_0001);

    // Simultaneous inv and ext: inv wins
    bus.exc_inv = 1'b1;
    bus.exc_ext = 1'b1;
    tick();
    bus.exc_inv = 1'b0;
    bus.exc_ext = 1'b0;
    chk("inv_beats_ext", 12'b10000100_0001);
    tick();
    tick();
    tick();
    chk("inv_ext_handler", 12'b00000010_0001);
    bus.eret = 1'b1;
    tick();
    bus.eret = 1'b0;
    tick();
    chk("back_idle", 12'b00000000_0001);

    // External IRQ alone, held high through the handler
    bus.exc_ext = 1'b1;
    tick();
    chk("ext_save_elr", 12'b10000100_0010);
    tick();
    chk("ext_save_esr", 12'b01000100_0010);
    tick();
    chk("ext_vector", 12'b00101100_0010);
    tick();
    chk("ext_in_handler", 12'b00000010_0010);
    tick();
    chk("ext_masked", 12'b00000010_0010);
    bus.eret = 1'b1;
    tick();
    bus.eret = 1'b0;
    chk("eret_beats_ext", 12'b00011110_0010);
    tick();
    chk("ret_idle_ext_pending", 12'b00000000_0010);
    tick();
    bus.exc_ext = 1'b0;
    chk("pending_ext_taken", 12'b10000100_0010);
    tick();
    tick();
    tick();
    chk("ext2_in_handler", 12'b00000010_0010);

    // Sync exception inside handler: double fault, no strobes
    bus.exc_inv = 1'b1;
    tick();
    bus.exc_inv = 1'b0;
    chk("double_fault", 12'b00000011_0010);
    tick();
    chk("double_fault_sticky", 12'b00000011_0010);
    bus.eret = 1'b1;
    tick();
    bus.eret = 1'b0;
    chk("df_return", 12'b00011111_0010);
    tick();
    chk("df_idle", 12'b00000001_0010);

    // ERET outside handler raises invalid-opcode entry
    bus.eret = 1'b1;
    tick();
    bus.eret = 1'b0;
    chk("eret_no_handler", 12'b10000101_0001);
    tick();
    chk("eret_nh_save_esr", 12'b01000101_0001);

    // Reset pulse in SAVE_ESR aborts the sequence
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("abort_reset", 12'b00000000_0000);
    tick();
    chk("abort_no_vector", 12'b00000000_0000);
    tick();
    chk("abort_idle", 12'b00000000_0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
